// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto a single request/response memory port.
// Optional FAIR_ARB_EN: round-robin between simultaneous requests instead of fixed data priority.
module mem_port_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        IReq,
  input  logic [31:0] IAddr,
  output logic [31:0] IRdata,
  output logic        IValid,
  input  logic        DReq,
  input  logic        DWe,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWdata,
  input  logic [3:0]  DBe,
  output logic [31:0] DRdata,
  output logic        DValid,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWdata,
  output logic [3:0]  MemBe,
  input  logic        MemReady,
  input  logic        MemRvalid,
  input  logic [31:0] MemRdata,
  output logic        StallF,
  output logic        StallM
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state_q;
  logic        win_data_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_be_q;
  logic        ivalid_q;
  logic        dvalid_q;
  logic [31:0] irdata_q;
  logic [31:0] drdata_q;
  logic        data_wins;

`ifdef FAIR_ARB_EN
  // 1 = last grant went to the data port
  logic        last_data_q;

  always_comb begin
    data_wins = DReq;
    if (DReq && IReq) begin
      data_wins = ~last_data_q;
    end
  end
`else
  always_comb begin
    data_wins = DReq;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      win_data_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      ivalid_q    <= 1'b0;
      dvalid_q    <= 1'b0;
      irdata_q    <= '0;
      drdata_q    <= '0;
`ifdef FAIR_ARB_EN
      last_data_q <= 1'b0;
`endif
    end else begin
      ivalid_q <= 1'b0;
      dvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (IReq || DReq) begin
            win_data_q <= data_wins;
            mem_req_q  <= 1'b1;
            state_q    <= REQ;
`ifdef FAIR_ARB_EN
            last_data_q <= data_wins;
`endif
            if (data_wins) begin
              mem_we_q    <= DWe;
              mem_addr_q  <= DAddr;
              mem_wdata_q <= DWdata;
              mem_be_q    <= DWe ? DBe : 4'b1111;
            end else begin
              mem_we_q    <= 1'b0;
              mem_addr_q  <= IAddr;
              mem_wdata_q <= '0;
              mem_be_q    <= 4'b1111;
            end
          end
        end
        REQ: begin
          if (MemReady) begin
            mem_req_q <= 1'b0;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (MemRvalid) begin
            state_q <= RESP;
            if (win_data_q) begin
              dvalid_q <= 1'b1;
              if (!mem_we_q) begin
                drdata_q <= MemRdata;
              end
            end else begin
              ivalid_q <= 1'b1;
              irdata_q <= MemRdata;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign MemReq   = mem_req_q;
  assign MemWe    = mem_we_q;
  assign MemAddr  = mem_addr_q;
  assign MemWdata = mem_wdata_q;
  assign MemBe    = mem_be_q;
  assign IValid   = ivalid_q;
  assign DValid   = dvalid_q;
  assign IRdata   = irdata_q;
  assign DRdata   = drdata_q;
  assign StallF   = IReq & ~ivalid_q;
  assign StallM   = DReq & ~dvalid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a memory model answers requests, a monitor
// checks every memory acceptance and every Valid pulse against queued expectations.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        IReq;
  logic [31:0] IAddr;
  logic [31:0] IRdata;
  logic        IValid;
  logic        DReq;
  logic        DWe;
  logic [31:0] DAddr;
  logic [31:0] DWdata;
  logic [3:0]  DBe;
  logic [31:0] DRdata;
  logic        DValid;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWdata;
  logic [3:0]  MemBe;
  logic        MemReady;
  logic        MemRvalid;
  logic [31:0] MemRdata;
  logic        StallF;
  logic        StallM;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .IReq(IReq), .IAddr(IAddr), .IRdata(IRdata), .IValid(IValid),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWdata(DWdata), .DBe(DBe),
    .DRdata(DRdata), .DValid(DValid),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata), .MemBe(MemBe),
    .MemReady(MemReady), .MemRvalid(MemRvalid), .MemRdata(MemRdata),
    .StallF(StallF), .StallM(StallM)
  );

  typedef struct {
    logic        is_f;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mreq_t;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
  } resp_t;

  mreq_t mq[$];
  resp_t rq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fetch_acc_cyc = 0;
  int data_acc_cyc = 0;
  logic [31:0] last_load = '0;

  int model_en = 1;
  int ready_delay = 0;
  int rv_delay = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : ((a ^ 32'h5A5A_0000) + 32'h11);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_fetch(input logic [31:0] a);
    mq.push_back('{1'b1, a, 1'b0, 32'h0, 4'hF});
    rq.push_back('{1'b0, mem_data(a)});
  endtask

  task automatic exp_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be);
    mq.push_back('{1'b0, a, we, wd, we ? be : 4'hF});
    if (!we) last_load = mem_data(a);
    rq.push_back('{1'b1, last_load});
  endtask

  // Memory model: acts mid-cycle so its outputs are stable at the next rising edge.
  int          seen = 0;
  int          rdy_cnt = 0;
  int          pend = 0;
  int          rv_wait = 0;
  logic [31:0] pend_addr = '0;

  initial begin
    MemReady  = 1'b0;
    MemRvalid = 1'b0;
    MemRdata  = '0;
    forever begin
      @(negedge clk);
      if (model_en != 0) begin
        MemRvalid = 1'b0;
        if (reset) begin
          seen = 0;
          pend = 0;
          MemReady = 1'b0;
        end else begin
          if (pend != 0) begin
            if (rv_wait == 0) begin
              MemRvalid = 1'b1;
              MemRdata  = mem_data(pend_addr);
              pend = 0;
            end else begin
              rv_wait--;
            end
          end
          MemReady = 1'b0;
          if (MemReq) begin
            if (seen == 0) begin
              seen = 1;
              rdy_cnt = ready_delay;
            end
            if (rdy_cnt == 0) begin
              MemReady  = 1'b1;
              seen      = 0;
              pend      = 1;
              rv_wait   = rv_delay;
              pend_addr = MemAddr;
            end else begin
              rdy_cnt--;
            end
          end
        end
      end
    end
  end

  // Monitor
  mreq_t       m;
  resp_t       r;
  logic        p_req = 1'b0;
  logic        p_rdy = 1'b0;
  logic        p_rst = 1'b1;
  logic        p_we;
  logic [31:0] p_addr;
  logic [31:0] p_wdata;
  logic [3:0]  p_be;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        if (p_req && !p_rdy && !p_rst) begin
          chk("hold_memreq", {31'b0, MemReq}, 32'd1);
          chk("hold_memaddr", MemAddr, p_addr);
          chk("hold_memwe", {31'b0, MemWe}, {31'b0, p_we});
          chk("hold_memwdata", MemWdata, p_wdata);
          chk("hold_membe", {28'b0, MemBe}, {28'b0, p_be});
        end
        if (MemReq && MemReady) begin
          if (mq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_unexpected: got request addr %h expected none", MemAddr);
          end else begin
            m = mq.pop_front();
            chk("mem_addr", MemAddr, m.addr);
            chk("mem_we", {31'b0, MemWe}, {31'b0, m.we});
            chk("mem_be", {28'b0, MemBe}, {28'b0, m.be});
            if (m.we) chk("mem_wdata", MemWdata, m.wdata);
            if (m.is_f) fetch_acc_cyc = cyc;
            else data_acc_cyc = cyc;
          end
        end
        if (IValid || DValid) begin
          chk("one_valid", {31'b0, IValid & DValid}, 32'd0);
          if (rq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL valid_unexpected: got IValid=%b DValid=%b expected none", IValid, DValid);
          end else begin
            r = rq.pop_front();
            chk("valid_port", {31'b0, DValid}, {31'b0, r.is_d});
            chk("rdata", DValid ? DRdata : IRdata, r.data);
          end
        end
      end
      p_req   = MemReq;
      p_rdy   = MemReady;
      p_rst   = reset;
      p_we    = MemWe;
      p_addr  = MemAddr;
      p_wdata = MemWdata;
      p_be    = MemBe;
    end
  end

  task automatic fetch_txn(input logic [31:0] a, input bit drop_early);
    int n;
    @(negedge clk);
    IReq  = 1'b1;
    IAddr = a;
    if (drop_early) begin
      @(negedge clk);
      IReq = 1'b0;
    end
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!IValid && n < 40);
    chk("fetch_done", {31'b0, IValid}, 32'd1);
    IReq = 1'b0;
  endtask

  task automatic data_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be);
    int n;
    @(negedge clk);
    DReq   = 1'b1;
    DWe    = we;
    DAddr  = a;
    DWdata = wd;
    DBe    = be;
    #2;
    chk("stallm_req", {31'b0, StallM}, 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!DValid && n < 40);
    chk("data_done", {31'b0, DValid}, 32'd1);
    DReq = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    IReq  = 1'b0;
    DReq  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    last_load = '0;
  endtask

  initial begin
    int c0;
    int n;
    reset  = 1'b1;
    IReq   = 1'b0;
    IAddr  = '0;
    DReq   = 1'b0;
    DWe    = 1'b0;
    DAddr  = '0;
    DWdata = '0;
    DBe    = '0;

    // Reset state, stalls follow requests even while in reset
    @(negedge clk);
    IReq = 1'b1;
    DReq = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("rst_stallf", {31'b0, StallF}, 32'd1);
    chk("rst_stallm", {31'b0, StallM}, 32'd1);
    chk("rst_memreq", {31'b0, MemReq}, 32'd0);
    chk("rst_memwe", {31'b0, MemWe}, 32'd0);
    chk("rst_memaddr", MemAddr, 32'd0);
    chk("rst_memwdata", MemWdata, 32'd0);
    chk("rst_membe", {28'b0, MemBe}, 32'd0);
    chk("rst_ivalid", {31'b0, IValid}, 32'd0);
    chk("rst_dvalid", {31'b0, DValid}, 32'd0);
    chk("rst_irdata", IRdata, 32'd0);
    chk("rst_drdata", DRdata, 32'd0);
    @(negedge clk);
    IReq  = 1'b0;
    DReq  = 1'b0;
    reset = 1'b0;

    // Minimum-latency fetch with stall timing
    exp_fetch(32'h100);
    @(negedge clk);
    IReq  = 1'b1;
    IAddr = 32'h100;
    c0 = cyc;
    #2;
    chk("f_stall_c0", {31'b0, StallF}, 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
      if (!IValid) chk("f_stall_wait", {31'b0, StallF}, 32'd1);
    end while (!IValid && n < 20);
    chk("f_latency", 32'(cyc - c0), 32'd3);
    chk("f_irdata", IRdata, 32'hDEADBEEF);
    IReq = 1'b0;

    // Load, then a stalled store that must leave DRdata alone
    exp_data(1'b0, 32'h500, 32'h0, 4'h0);
    data_txn(1'b0, 32'h500, 32'h0, 4'h0);
    ready_delay = 3;
    exp_data(1'b1, 32'h504, 32'hCAFEF00D, 4'b0011);
    data_txn(1'b1, 32'h504, 32'hCAFEF00D, 4'b0011);
    ready_delay = 0;
    chk("store_drdata_kept", DRdata, mem_data(32'h500));

    // Fetch dropped right after grant still completes
    exp_fetch(32'h104);
    fetch_txn(32'h104, 1'b1);

    // Slow response
    rv_delay = 2;
    exp_data(1'b0, 32'h600, 32'h0, 4'h0);
    data_txn(1'b0, 32'h600, 32'h0, 4'h0);
    rv_delay = 0;

    // Simultaneous requests: data first, fetch granted in the IDLE cycle after RESP
    do_reset();
    exp_data(1'b0, 32'h2000, 32'h0, 4'h0);
    exp_fetch(32'h3000);
    fork
      data_txn(1'b0, 32'h2000, 32'h0, 4'h0);
      fetch_txn(32'h3000, 1'b0);
    join
    chk("b2b_fetch_gap", 32'(fetch_acc_cyc - data_acc_cyc), 32'd4);

    // Both ports held for two transactions each
    do_reset();
`ifdef FAIR_ARB_EN
    exp_data(1'b0, 32'h2100, 32'h0, 4'h0);
    exp_fetch(32'h3100);
    exp_data(1'b0, 32'h2104, 32'h0, 4'h0);
    exp_fetch(32'h3104);
`else
    exp_data(1'b0, 32'h2100, 32'h0, 4'h0);
    exp_data(1'b0, 32'h2104, 32'h0, 4'h0);
    exp_fetch(32'h3100);
    exp_fetch(32'h3104);
`endif
    fork
      begin
        data_txn(1'b0, 32'h2100, 32'h0, 4'h0);
        data_txn(1'b0, 32'h2104, 32'h0, 4'h0);
      end
      begin
        fetch_txn(32'h3100, 1'b0);
        fetch_txn(32'h3104, 1'b0);
      end
    join

    // Reset during WAIT aborts silently; a late MemRvalid is ignored
    do_reset();
    model_en = 0;
    MemReady  = 1'b0;
    MemRvalid = 1'b0;
    mq.push_back('{1'b0, 32'h40, 1'b0, 32'h0, 4'hF});
    @(negedge clk);
    DReq  = 1'b1;
    DWe   = 1'b0;
    DAddr = 32'h40;
    @(negedge clk);
    MemReady = 1'b1;
    #2;
    chk("abort_memreq_up", {31'b0, MemReq}, 32'd1);
    @(negedge clk);
    MemReady = 1'b0;
    DReq  = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #2;
    chk("abort_memreq", {31'b0, MemReq}, 32'd0);
    chk("abort_dvalid", {31'b0, DValid}, 32'd0);
    chk("abort_ivalid", {31'b0, IValid}, 32'd0);
    MemRvalid = 1'b1;
    MemRdata  = 32'hBADBAD00;
    @(negedge clk);
    MemRvalid = 1'b0;
    #2;
    chk("late_rv_dvalid", {31'b0, DValid}, 32'd0);
    chk("late_rv_drdata", DRdata, 32'd0);
    chk("late_rv_memreq", {31'b0, MemReq}, 32'd0);
    @(negedge clk);
    #2;
    chk("late_rv_dvalid2", {31'b0, DValid}, 32'd0);
    chk("late_rv_ivalid2", {31'b0, IValid}, 32'd0);
    model_en = 1;

    repeat (3) @(negedge clk);
    chk("mq_empty", 32'(mq.size()), 32'd0);
    chk("rq_empty", 32'(rq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
